// File: rtl/exe_wb_skid_stage_pkg.sv
// ============================================================================
// Module      : exe_wb_skid_stage_pkg
// Description : Shared pipeline widths used by every stage of the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_wb_skid_stage_pkg;

    localparam int c_DSIZE_DEF = 32;
    localparam int c_ASIZE_DEF = 5;

endpackage : exe_wb_skid_stage_pkg

`default_nettype wire

// File: rtl/exe_wb_skid_stage_pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline holding slot: valid bit plus {alu, addr, wen}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import exe_wb_skid_stage_pkg::*;
#(
    parameter int DSIZE = c_DSIZE_DEF,
    parameter int ASIZE = c_ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_load,
    input  logic [DSIZE-1:0] i_alu,
    input  logic [ASIZE-1:0] i_addr,
    input  logic             i_wen,
    output logic             o_valid,
    output logic [DSIZE-1:0] o_alu,
    output logic [ASIZE-1:0] o_addr,
    output logic             o_wen
);

    logic             r_valid;
    logic [DSIZE-1:0] r_alu;
    logic [ASIZE-1:0] r_addr;
    logic             r_wen;

    // Valid follows its next-state every cycle; payload only moves on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_load) begin
                r_alu  <= i_alu;
                r_addr <= i_addr;
                r_wen  <= i_wen;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_alu   = r_alu;
    assign o_addr  = r_addr;
    assign o_wen   = r_wen;

endmodule : pipe_slot

`default_nettype wire

// File: rtl/exe_wb_skid_stage.sv
// ============================================================================
// Module      : exe_wb_skid_stage
// Description : EXE->WB two-entry skid buffer with registered ready and
//               saturating back-pressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_wb_skid_stage
    import exe_wb_skid_stage_pkg::*;
#(
    parameter int DSIZE = c_DSIZE_DEF,
    parameter int ASIZE = c_ASIZE_DEF,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] aluin,
    input  logic [ASIZE-1:0] muxin,
    input  logic             wenin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] aluout,
    output logic [ASIZE-1:0] muxout,
    output logic             wenout,
    output logic [CNTW-1:0]  stall_cnt
);

    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic             r_in_ready;
    logic [CNTW-1:0]  r_stall_cnt;

    logic             w_main_valid, w_main_wen;
    logic             w_skid_valid, w_skid_wen;
    logic [DSIZE-1:0] w_skid_alu;
    logic [ASIZE-1:0] w_skid_addr;

    logic             w_accept, w_drain, w_main_free;
    logic             w_main_vnext, w_main_load, w_main_from_skid;
    logic             w_skid_vnext, w_skid_load;
    logic [DSIZE-1:0] w_main_alu_d;
    logic [ASIZE-1:0] w_main_addr_d;
    logic             w_main_wen_d;

    assign w_accept    = in_valid & r_in_ready;
    assign w_drain     = w_main_valid & out_ready;
    assign w_main_free = ~w_main_valid | w_drain;

    // Flush only kills valid bits; payload loads are suppressed with it.
    always_comb begin
        w_main_vnext     = w_main_valid;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_vnext     = w_skid_valid;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_main_vnext = 1'b0;
            w_skid_vnext = 1'b0;
        end else if (w_main_free) begin
            if (w_skid_valid) begin
                w_main_vnext     = 1'b1;
                w_main_load      = 1'b1;
                w_main_from_skid = 1'b1;
                w_skid_vnext     = 1'b0;
            end else begin
                w_main_vnext = w_accept;
                w_main_load  = w_accept;
            end
        end else if (w_accept) begin
            w_skid_vnext = 1'b1;
            w_skid_load  = 1'b1;
        end
    end

    assign w_main_alu_d  = w_main_from_skid ? w_skid_alu  : aluin;
    assign w_main_addr_d = w_main_from_skid ? w_skid_addr : muxin;
    assign w_main_wen_d  = w_main_from_skid ? w_skid_wen  : wenin;

    pipe_slot #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_main_vnext),
        .i_load  (w_main_load),
        .i_alu   (w_main_alu_d),
        .i_addr  (w_main_addr_d),
        .i_wen   (w_main_wen_d),
        .o_valid (w_main_valid),
        .o_alu   (aluout),
        .o_addr  (muxout),
        .o_wen   (w_main_wen)
    );

    pipe_slot #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_skid_vnext),
        .i_load  (w_skid_load),
        .i_alu   (aluin),
        .i_addr  (muxin),
        .i_wen   (wenin),
        .o_valid (w_skid_valid),
        .o_alu   (w_skid_alu),
        .o_addr  (w_skid_addr),
        .o_wen   (w_skid_wen)
    );

    // Ready is the registered complement of the next skid state, so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_in_ready <= ~w_skid_vnext;
            if (w_main_valid && !out_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign wenout    = w_main_wen & w_main_valid;
    assign stall_cnt = r_stall_cnt;

endmodule : exe_wb_skid_stage

`default_nettype wire

// File: tb/tb_exe_wb_skid_stage.sv
// ============================================================================
// Module      : tb_exe_wb_skid_stage
// Description : Scoreboard bench for exe_wb_skid_stage (FIFO reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_wb_skid_stage;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_CW = 4;

    typedef struct packed {
        logic [c_DW-1:0] alu;
        logic [c_AW-1:0] addr;
        logic            wen;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [c_DW-1:0] aluin;
    logic [c_AW-1:0] muxin;
    logic            wenin;
    logic            out_valid;
    logic            out_ready;
    logic [c_DW-1:0] aluout;
    logic [c_AW-1:0] muxout;
    logic            wenout;
    logic [c_CW-1:0] stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];
    logic m_ready;
    logic m_acc;
    int   m_cnt;

    always #5 clk = ~clk;

    exe_wb_skid_stage #(
        .DSIZE (c_DW),
        .ASIZE (c_AW),
        .CNTW  (c_CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluin     (aluin),
        .muxin     (muxin),
        .wenin     (wenin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .muxout    (muxout),
        .wenout    (wenout),
        .stall_cnt (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic v;
        v = (q.size() > 0);
        check_eq("out_valid", {63'd0, out_valid}, {63'd0, v});
        check_eq("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
        check_eq("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
        check_eq("wenout", {63'd0, wenout}, {63'd0, v ? q[0].wen : 1'b0});
        if (v) begin
            check_eq("aluout", {32'd0, aluout}, {32'd0, q[0].alu});
            check_eq("muxout", {59'd0, muxout}, {59'd0, q[0].addr});
        end
    endtask

    // One clock: advance the reference model with the pre-edge inputs, then compare.
    task automatic step();
        logic pre_v;
        @(posedge clk);
        pre_v = (q.size() > 0);
        m_acc = 1'b0;
        if (pre_v && !out_ready && m_cnt < 15) m_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (pre_v && out_ready) void'(q.pop_front());
            if (in_valid && m_ready) begin
                q.push_back('{alu: aluin, addr: muxin, wen: wenin});
                m_acc = 1'b1;
            end
        end
        m_ready = (q.size() < 2);
        #1;
        compare_outputs();
    endtask

    task automatic push(input logic [c_DW-1:0] a, input logic [c_AW-1:0] d, input logic w);
        int k;
        in_valid = 1'b1;
        aluin    = a;
        muxin    = d;
        wenin    = w;
        k = 0;
        do begin
            step();
            k++;
        end while (!m_acc && k < 50);
        if (!m_acc) check_eq("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        aluin     = 32'hDEAD_BEEF;
        muxin     = 5'd7;
        wenin     = 1'b1;
        out_ready = 1'b0;
        m_ready   = 1'b1;
        m_cnt     = 0;
        #12;
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_aluout", {32'd0, aluout}, 64'd0);
        check_eq("rst_muxout", {59'd0, muxout}, 64'd0);
        check_eq("rst_wenout", {63'd0, wenout}, 64'd0);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Streaming: back-to-back entries with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(32'h10 + 32'(i), c_AW'(i), 1'b1);
        step();
        step();

        // Back-pressure: A in main, B in skid, C held off until release.
        out_ready = 1'b0;
        push(32'hAAAA, 5'd1, 1'b1);
        push(32'hBBBB, 5'd2, 1'b0);
        in_valid = 1'b1;
        aluin    = 32'hCCCC;
        muxin    = 5'd3;
        wenin    = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("bp_c_blocked", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        push(32'hCCCC, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) step();

        // Flush with both slots full and a live input the same cycle.
        out_ready = 1'b0;
        push(32'hA1, 5'd4, 1'b1);
        push(32'hB1, 5'd5, 1'b1);
        in_valid = 1'b1;
        aluin    = 32'hC1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("flush_wenout", {63'd0, wenout}, 64'd0);
        step();
        check_eq("flush_c_absent", {63'd0, out_valid}, 64'd0);

        // Saturation: one held entry, consumer stalled for 20 cycles.
        push(32'h5A5A, 5'd9, 1'b1);
        for (int i = 0; i < 20; i++) step();
        check_eq("stall_sat", {60'd0, stall_cnt}, 64'd15);

        // Asynchronous reset between edges with both slots occupied.
        push(32'h7777, 5'd10, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        check_eq("arst_aluout", {32'd0, aluout}, 64'd0);
        q.delete();
        m_ready = 1'b1;
        m_cnt   = 0;
        #1;
        rst = 1'b0;

        // Random traffic against the FIFO model.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            aluin     = $urandom;
            muxin     = c_AW'($urandom);
            wenin     = 1'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exe_wb_skid_stage

`default_nettype wire

// File: doc/exe_wb_skid_stage.md
EXE_WB_SKID_STAGE -- requirements
Module: exe_wb_skid_stage

Interface
REQ-001 Parameter DSIZE, default 32, ALU result width in bits (≥1).
REQ-002 Parameter ASIZE, default 5, destination register address width in bits (≥1).
REQ-003 Parameter CNTW, default 16, stall counter width in bits (≥2).
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream EXE result valid.
REQ-008 in_ready  output  1  stage can accept this cycle.
REQ-009 aluin  input  DSIZE  EXE ALU result.
REQ-010 muxin  input  ASIZE  EXE destination register address.
REQ-011 wenin  input  1  EXE register-write enable.
REQ-012 out_valid  output  1  WB entry valid.
REQ-013 out_ready  input  1  WB consumes the entry this cycle.
REQ-014 aluout  output  DSIZE  WB ALU result.
REQ-015 muxout  output  ASIZE  WB destination address.
REQ-016 wenout  output  1  WB write enable, SHALL equal stored wen AND out_valid.
REQ-017 stall_cnt  output  CNTW  count of back-pressured cycles.

Function
REQ-018 The stage SHALL be a two-entry skid buffer: main slot drives outputs; skid slot holds one overflow entry.
REQ-019 in_ready SHALL be registered and equal NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-020 Accept = in_valid AND in_ready; Drain = out_valid AND out_ready.
REQ-021 Main empty or Drain: main SHALL load from skid if skid_valid, else from input if Accept, else become invalid.
REQ-022 Main full, no Drain, Accept: input SHALL be written to skid; skid_valid set.
REQ-023 Skid SHALL clear when it moves into main; entries leave in arrival order (FIFO, no reordering or loss).
REQ-024 Latency: an accepted entry into an empty stage SHALL appear on outputs the next cycle; throughput one entry per cycle when out_ready held high.
REQ-025 flush SHALL clear both valid bits at the next edge with priority over Accept and Drain; a same-cycle input is discarded; data fields may hold stale values.
REQ-026 Data fields SHALL load only with their slot; aluout/muxout hold when no load occurs.
REQ-027 stall_cnt SHALL increment when out_valid AND NOT out_ready, saturate at all-ones, and not wrap.
REQ-028 flush SHALL NOT clear stall_cnt.

Reset
REQ-029 On rst: out_valid=0, skid_valid=0, in_ready=1, aluout=0, muxout=0, wenout=0, stall_cnt=0, skid data=0.
REQ-030 rst asserted mid-transfer SHALL discard both entries immediately, independent of clk.
REQ-031 First Accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 DSIZE and ASIZE defaults SHALL come from the shared define header used by all pipeline stages; CNTW local.
REQ-033 One sub-module pipe_slot (valid + {alu, addr, wen}, async reset, load enable) SHALL be instantiated twice (main, skid).

Verification
REQ-034 Reset: rst=1 with in_valid=1 -> out_valid=0, aluout=0, muxout=0, in_ready=1, stall_cnt=0.
REQ-035 Streaming: out_ready=1, ten entries aluin=0x10+i, muxin=i, wenin=1 -> each on outputs one cycle later, in order, no bubbles.
REQ-036 Back-pressure: out_ready=0, push A=0xAAAA, B=0xBBBB, C -> A on outputs, B in skid, in_ready=0, C not accepted; release -> A, B, C in order.
REQ-037 Flush: main=A, skid=B, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, in_ready=1, C absent, wenout=0.
REQ-038 Saturation: CNTW=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-039 Async reset mid-op: rst pulse between edges with both slots full -> out_valid and in_ready change before the next edge.
